// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the stream-lock state type.
package vga_timing_pkg;
  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HB = 48;
  localparam int HR = 96;
  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VB = 33;
  localparam int VR = 2;
  localparam int H_TOTAL = HD + HF + HB + HR;
  localparam int V_TOTAL = VD + VF + VB + VR;

  typedef enum logic {WAIT = 1'b0, RUN = 1'b1} sync_state_t;
endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters with combinational display, sync and frame-origin decodes.
module vga_timing_counter #(
  parameter int HD = vga_timing_pkg::HD,
  parameter int HF = vga_timing_pkg::HF,
  parameter int HB = vga_timing_pkg::HB,
  parameter int HR = vga_timing_pkg::HR,
  parameter int VD = vga_timing_pkg::VD,
  parameter int VF = vga_timing_pkg::VF,
  parameter int VB = vga_timing_pkg::VB,
  parameter int VR = vga_timing_pkg::VR,
  parameter int HW = $clog2(HD + HF + HB + HR),
  parameter int VW = $clog2(VD + VF + VB + VR)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          video_on,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          frame_origin
);
  import vga_timing_pkg::*;

  localparam int H_LAST = HD + HF + HB + HR - 1;
  localparam int V_LAST = VD + VF + VB + VR - 1;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;

  // v_cnt advances (or wraps) on the same edge that h_cnt wraps
  always_comb begin
    h_wrap  = (h_cnt_q == HW'(H_LAST));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VW'(V_LAST)) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt        = h_cnt_q;
  assign v_cnt        = v_cnt_q;
  assign video_on     = (h_cnt_q < HW'(HD)) && (v_cnt_q < VW'(VD));
  assign hsync_n      = !((h_cnt_q >= HW'(HD + HF)) && (h_cnt_q <= HW'(HD + HF + HR - 1)));
  assign vsync_n      = !((v_cnt_q >= VW'(VD + VF)) && (v_cnt_q <= VW'(VD + VF + VR - 1)));
  assign frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
endmodule

// File: rtl/vga_stream_sync.sv
// Locks a {start, color} pixel stream to VGA raster timing and drives registered DAC outputs.
module vga_stream_sync #(
  parameter int CD = 12,
  parameter int HD = vga_timing_pkg::HD,
  parameter int HF = vga_timing_pkg::HF,
  parameter int HB = vga_timing_pkg::HB,
  parameter int HR = vga_timing_pkg::HR,
  parameter int VD = vga_timing_pkg::VD,
  parameter int VF = vga_timing_pkg::VF,
  parameter int VB = vga_timing_pkg::VB,
  parameter int VR = vga_timing_pkg::VR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CD:0]   si_data,
  input  logic          si_valid,
  output logic          si_ready,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic          locked,
  output logic          underflow
);
  import vga_timing_pkg::*;

  localparam int HW = $clog2(HD + HF + HB + HR);
  localparam int VW = $clog2(VD + VF + VB + VR);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          video_on, hsync_n, vsync_n, frame_origin;
  logic          cnt_unused;

  sync_state_t   state_q, state_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          underflow_q, underflow_d;
  logic [CD-1:0] rgb_q, rgb_d;
  logic          sof;
  logic [CD-1:0] color;

  assign sof   = si_data[CD];
  assign color = si_data[CD-1:0];

  vga_timing_counter #(
    .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .video_on     (video_on),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .frame_origin (frame_origin)
  );

  // Raw counters are exposed by the timing block as debug taps only.
  assign cnt_unused = ^{h_cnt, v_cnt};

  always_comb begin
    state_d     = state_q;
    si_ready    = 1'b0;
    rgb_d       = '0;
    underflow_d = underflow_q;
    hsync_d     = hsync_n;
    vsync_d     = vsync_n;
    case (state_q)
      WAIT: begin
        // The start word is popped on the lock cycle so stream pixel 0 lands on (0,0).
        if (frame_origin && si_valid && sof) begin
          state_d  = RUN;
          si_ready = 1'b1;
          rgb_d    = color;
        end else begin
          si_ready = si_valid && !sof;
        end
      end
      RUN: begin
        si_ready = video_on && si_valid;
        if (video_on) begin
          if (!si_valid) begin
            underflow_d = 1'b1;
          end else if (sof != frame_origin) begin
            state_d = WAIT;
          end else begin
            rgb_d = color;
          end
        end
      end
      default: state_d = WAIT;
    endcase
    if (reset) begin
      si_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign rgb       = rgb_q;
  assign locked    = (state_q == RUN);
  assign underflow = underflow_q;
endmodule

// File: tb/tb_vga_stream_sync.sv
// Directed bench for vga_stream_sync on a 12x7 raster with a queue standing in for the line buffer.
module tb_vga_stream_sync;
  localparam int CD = 12;
  localparam int HD = 8, HF = 1, HB = 1, HR = 2;
  localparam int VD = 4, VF = 1, VB = 1, VR = 1;
  localparam int HT = 12, VT = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CD:0]   si_data = '0;
  logic          si_valid = 1'b0;
  logic          si_ready, hsync, vsync, locked, underflow;
  logic [CD-1:0] rgb;

  always #5 clk = ~clk;

  vga_stream_sync #(
    .CD(CD), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .si_data   (si_data),
    .si_valid  (si_valid),
    .si_ready  (si_ready),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb),
    .locked    (locked),
    .underflow (underflow)
  );

  logic [CD:0] fifo[$];
  int checks = 0, errors = 0;
  int mh = 0, mv = 0;
  logic exp_hs = 1'b1, exp_vs = 1'b1, vs_prev = 1'b1;
  int cyc = 0, last_fall = -1, n_period = 0;
  bit measure = 0, chk_vo = 0;
  logic [CD-1:0] t4_rgb [4] = '{12'h300, 12'h301, 12'h302, 12'h000};
  logic          t4_lck [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (fifo.size() > 0) begin
      si_valid = 1'b1;
      si_data  = fifo[0];
    end else begin
      si_valid = 1'b0;
      si_data  = '0;
    end
    #1;
  endtask

  // One clock: pop on handshake, advance the raster model, check sync outputs.
  task automatic tick();
    bit pop, vo;
    int ph, pv;
    pop = si_valid && si_ready;
    ph  = mh;
    pv  = mv;
    vo  = (ph < HD) && (pv < VD);
    if (pop && chk_vo) check("pop_in_video", 32'(vo), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    if (pop) void'(fifo.pop_front());
    if (reset) begin
      mh = 0; mv = 0; exp_hs = 1'b1; exp_vs = 1'b1;
    end else begin
      exp_hs = !(ph >= 9 && ph <= 10);
      exp_vs = !(pv == 5);
      mh = (ph == HT - 1) ? 0 : ph + 1;
      if (ph == HT - 1) mv = (pv == VT - 1) ? 0 : pv + 1;
    end
    drive();
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
    if (vs_prev && !vsync) begin
      if (measure && last_fall >= 0) begin
        check("frame_period", 32'(cyc - last_fall), 32'd84);
        n_period++;
      end
      last_fall = cyc;
    end
    vs_prev = vsync;
  endtask

  task automatic push_frame(input logic [CD-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo.push_back({(i == 0), base + CD'(i)});
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 200) begin
      tick();
      n++;
    end
    check("reach_pos", 32'(mh == h && mv == v), 32'd1);
  endtask

  // Wait in WAIT for (0,0) while the start word sits at the head unpopped.
  task automatic wait_origin_hold(input int keep);
    int n = 0;
    while (!(mh == 0 && mv == 0) && n < 200) begin
      check("hold_ready", 32'(si_ready), 32'd0);
      check("hold_depth", 32'(fifo.size()), 32'(keep));
      tick();
      n++;
    end
    check("reach_origin", 32'(mh == 0 && mv == 0), 32'd1);
    check("lock_ready", 32'(si_ready), 32'd1);
  endtask

  task automatic run_frame(input logic [CD-1:0] base, input int npix, input bit uf0);
    bit uf;
    int ph, pv, idx;
    logic [CD-1:0] e;
    uf = uf0;
    for (int k = 0; k < HT * VT; k++) begin
      ph  = mh;
      pv  = mv;
      idx = pv * HD + ph;
      e   = '0;
      if (ph < HD && pv < VD) begin
        if (idx < npix) e = base + CD'(idx);
        else uf = 1'b1;
      end
      tick();
      check("rgb", 32'(rgb), 32'(e));
      check("locked_run", 32'(locked), 32'd1);
      check("underflow", 32'(underflow), 32'(uf));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, idle stream
    drive();
    repeat (3) tick();
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_ready", 32'(si_ready), 32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_rgb", 32'(rgb), 32'd0);
      check("idle_locked", 32'(locked), 32'd0);
      check("idle_ready", 32'(si_ready), 32'd0);
    end

    // 2: junk words, lock, one full frame; then 3: frame that runs dry at (5,1)
    wait_pos(0, 3);
    fifo.push_back({1'b0, 12'hAAA});
    fifo.push_back({1'b0, 12'hBBB});
    fifo.push_back({1'b0, 12'hCCC});
    push_frame(12'h100, 32);
    push_frame(12'h400, 13);
    drive();
    check("junk_ready", 32'(si_ready), 32'd1);
    repeat (3) tick();
    check("junk_popped", 32'(fifo.size()), 32'd45);
    check("wait_locked", 32'(locked), 32'd0);
    wait_origin_hold(45);
    run_frame(12'h100, 32, 1'b0);
    check("frame_a_used", 32'(fifo.size()), 32'd13);
    run_frame(12'h400, 13, 1'b0);
    check("frame_b_empty", 32'(fifo.size()), 32'd0);

    // 4: start flag on pixel 3 -> black, unlock, drop junk, relock at (0,0)
    fifo.push_back({1'b1, 12'h300});
    fifo.push_back({1'b0, 12'h301});
    fifo.push_back({1'b0, 12'h302});
    fifo.push_back({1'b1, 12'h303});
    fifo.push_back({1'b0, 12'h3F0});
    fifo.push_back({1'b0, 12'h3F1});
    push_frame(12'h100, 32);
    drive();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mis_rgb", 32'(rgb), 32'(t4_rgb[i]));
      check("mis_locked", 32'(locked), 32'(t4_lck[i]));
    end
    repeat (2) tick();
    check("mis_junk", 32'(fifo.size()), 32'd32);
    check("mis_sticky_uf", 32'(underflow), 32'd1);
    wait_origin_hold(32);
    run_frame(12'h100, 32, 1'b1);

    // 5: one-cycle reset mid-line 2 with a word waiting
    wait_pos(3, 2);
    fifo.push_back({1'b0, 12'h555});
    drive();
    reset = 1'b1;
    #1;
    check("rst_no_pop_ready", 32'(si_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_underflow", 32'(underflow), 32'd0);
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_vsync", 32'(vsync), 32'd1);
    check("mid_rst_depth", 32'(fifo.size()), 32'd1);
    check("post_rst_ready", 32'(si_ready), 32'd1);
    tick();
    check("post_rst_drop", 32'(fifo.size()), 32'd0);

    // 6: three locked frames back to back
    push_frame(12'h100, 32);
    push_frame(12'h100, 32);
    push_frame(12'h100, 32);
    drive();
    wait_origin_hold(96);
    measure   = 1;
    chk_vo    = 1;
    last_fall = -1;
    run_frame(12'h100, 32, 1'b0);
    run_frame(12'h100, 32, 1'b0);
    run_frame(12'h100, 32, 1'b0);
    check("free_run_empty", 32'(fifo.size()), 32'd0);
    check("period_count", 32'(n_period >= 2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
